// File: rtl/lb_pop_arb_pkg.sv
// Shared types and constants for the ListBuffer pop arbiter.
// Holds the queue count, widths, request field offsets, the packed request
// struct and the output-register state enum.
package lb_pop_arb_pkg;

    localparam int unsigned NUM_Q  = 21;
    localparam int unsigned IDX_W  = 5;
    localparam int unsigned DATA_W = 48;

    // Request field offsets (LSB) and widths
    localparam int unsigned PRIO0_LSB   = 0;
    localparam int unsigned PRIO1_LSB   = 1;
    localparam int unsigned PRIO2_LSB   = 2;
    localparam int unsigned CONTROL_LSB = 3;
    localparam int unsigned OPCODE_LSB  = 4;
    localparam int unsigned OPCODE_W    = 3;
    localparam int unsigned PARAM_LSB   = 7;
    localparam int unsigned PARAM_W     = 3;
    localparam int unsigned SIZE_LSB    = 10;
    localparam int unsigned SIZE_W      = 3;
    localparam int unsigned SOURCE_LSB  = 13;
    localparam int unsigned SOURCE_W    = 6;
    localparam int unsigned TAG_LSB     = 19;
    localparam int unsigned TAG_W       = 17;
    localparam int unsigned OFFSET_LSB  = 36;
    localparam int unsigned OFFSET_W    = 6;
    localparam int unsigned PUT_LSB     = 42;
    localparam int unsigned PUT_W       = 6;

    typedef struct packed {
        logic [PUT_W-1:0]    put;
        logic [OFFSET_W-1:0] offset;
        logic [TAG_W-1:0]    tag;
        logic [SOURCE_W-1:0] source;
        logic [SIZE_W-1:0]   size;
        logic [PARAM_W-1:0]  param;
        logic [OPCODE_W-1:0] opcode;
        logic                control;
        logic                prio_2;
        logic                prio_1;
        logic                prio_0;
    } req_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    // Unpack a raw ListBuffer word into the request struct by field offset
    function automatic req_t req_from_bits(input logic [DATA_W-1:0] b);
        req_t r;
        r.prio_0  = b[PRIO0_LSB];
        r.prio_1  = b[PRIO1_LSB];
        r.prio_2  = b[PRIO2_LSB];
        r.control = b[CONTROL_LSB];
        r.opcode  = b[OPCODE_LSB +: OPCODE_W];
        r.param   = b[PARAM_LSB +: PARAM_W];
        r.size    = b[SIZE_LSB +: SIZE_W];
        r.source  = b[SOURCE_LSB +: SOURCE_W];
        r.tag     = b[TAG_LSB +: TAG_W];
        r.offset  = b[OFFSET_LSB +: OFFSET_W];
        r.put     = b[PUT_LSB +: PUT_W];
        return r;
    endfunction

endpackage

// File: rtl/lb_pop_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Ports: req  - request vector (NUM_Q)
//        ptr  - first index to consider (inclusive)
//        any  - at least one request set
//        idx  - first set request at or after ptr, wrapping
module rr_pick
    import lb_pop_arb_pkg::*;
(
    input  logic [NUM_Q-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    localparam int unsigned SUM_W = IDX_W + 1;

    logic [NUM_Q-1:0] w_rot;
    logic [IDX_W-1:0] w_off;
    logic [SUM_W-1:0] w_sum;

    // Doubling the vector turns the wrap-around into a plain right shift
    assign w_rot = NUM_Q'({req, req} >> ptr);

    // Lowest set bit of the rotated vector is the distance from ptr
    always_comb begin
        w_off = '0;
        for (int i = NUM_Q - 1; i >= 0; i--) begin
            if (w_rot[i]) w_off = IDX_W'(i);
        end
    end

    assign w_sum = {1'b0, ptr} + {1'b0, w_off};
    assign idx   = (w_sum >= SUM_W'(NUM_Q)) ? IDX_W'(w_sum - SUM_W'(NUM_Q))
                                            : IDX_W'(w_sum);
    assign any   = |req;

endmodule

// File: rtl/lb_pop_arbiter.sv
// lb_pop_arbiter: pops one eligible ListBuffer queue per cycle in round-robin
// order and holds the request in a one-entry valid/ready output register.
// Ports: clock/reset (async active-low), lb_valid/lb_pop_valid/lb_pop_bits/
//        lb_data (ListBuffer side), mshr_free (per-MSHR availability),
//        out_valid/out_ready/out_idx/out_data (allocation stage side).
// Optional: LB_POP_ARB_STATS_EN adds saturating stat_pops/stat_stalls.
module lb_pop_arbiter
    import lb_pop_arb_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_Q-1:0]  lb_valid,
    output logic              lb_pop_valid,
    output logic [IDX_W-1:0]  lb_pop_bits,
    input  logic [DATA_W-1:0] lb_data,
    input  logic [NUM_Q-1:0]  mshr_free,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_idx,
    output logic [DATA_W-1:0] out_data
`ifdef LB_POP_ARB_STATS_EN
    ,
    output logic [31:0]       stat_pops,
    output logic [31:0]       stat_stalls
`endif
);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [NUM_Q-1:0] r_claimed;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] r_out_idx;
    req_t             r_out_data;

    logic [NUM_Q-1:0] w_elig;
    logic             w_any;
    logic [IDX_W-1:0] w_grant;
    logic             w_slot_free;
    logic [NUM_Q-1:0] w_pop_oh;

    // A queue stays claimed from its pop until its MSHR reports busy
    assign w_elig = lb_valid & mshr_free & ~r_claimed;

    rr_pick u_rr_pick (
        .req (w_elig),
        .ptr (r_rr_ptr),
        .any (w_any),
        .idx (w_grant)
    );

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= EMPTY;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY: if (lb_pop_valid) w_state_nxt = FULL;
            FULL:  if (out_ready && !lb_pop_valid) w_state_nxt = EMPTY;
            default: w_state_nxt = EMPTY;
        endcase
    end

    // Output logic; pop is gated by reset so nothing is popped while held in reset
    always_comb begin
        out_valid    = (r_state == FULL);
        w_slot_free  = !out_valid || out_ready;
        lb_pop_valid = w_any && w_slot_free && reset;
        lb_pop_bits  = lb_pop_valid ? w_grant : '0;
    end

    assign w_pop_oh = lb_pop_valid ? (NUM_Q'(1) << w_grant) : '0;

    // Payload capture, pointer advance and claim tracking
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_out_idx  <= '0;
            r_out_data <= '0;
            r_rr_ptr   <= '0;
            r_claimed  <= '0;
        end else begin
            if (lb_pop_valid) begin
                r_out_idx  <= w_grant;
                r_out_data <= req_from_bits(lb_data);
                r_rr_ptr   <= (w_grant == IDX_W'(NUM_Q - 1)) ? '0 : w_grant + IDX_W'(1);
            end
            r_claimed <= (r_claimed & mshr_free) | w_pop_oh;
        end
    end

    assign out_idx  = r_out_idx;
    assign out_data = r_out_data;

`ifdef LB_POP_ARB_STATS_EN
    logic [31:0] r_stat_pops;
    logic [31:0] r_stat_stalls;

    // Saturating event counters
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_stat_pops   <= '0;
            r_stat_stalls <= '0;
        end else begin
            if (lb_pop_valid && (r_stat_pops != '1))
                r_stat_pops <= r_stat_pops + 32'd1;
            if (out_valid && !out_ready && (r_stat_stalls != '1))
                r_stat_stalls <= r_stat_stalls + 32'd1;
        end
    end

    assign stat_pops   = r_stat_pops;
    assign stat_stalls = r_stat_stalls;
`endif

endmodule

// File: tb/tb_lb_pop_arbiter.sv
// Scoreboard bench for lb_pop_arbiter with a set/arithmetic reference model.
module tb_lb_pop_arbiter;

    localparam int NQ = 21;

    logic        clock;
    logic        reset;
    logic [20:0] lb_valid;
    logic        lb_pop_valid;
    logic [4:0]  lb_pop_bits;
    logic [47:0] lb_data;
    logic [20:0] mshr_free;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_idx;
    logic [47:0] out_data;
`ifdef LB_POP_ARB_STATS_EN
    logic [31:0] stat_pops;
    logic [31:0] stat_stalls;
`endif

    lb_pop_arbiter dut (
        .clock        (clock),
        .reset        (reset),
        .lb_valid     (lb_valid),
        .lb_pop_valid (lb_pop_valid),
        .lb_pop_bits  (lb_pop_bits),
        .lb_data      (lb_data),
        .mshr_free    (mshr_free),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_idx      (out_idx),
        .out_data     (out_data)
`ifdef LB_POP_ARB_STATS_EN
        ,
        .stat_pops    (stat_pops),
        .stat_stalls  (stat_stalls)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int          idx;
        logic [47:0] data;
    } exp_t;

    exp_t        sb[$];
    bit [20:0]   m_claimed;
    int          m_ptr;
    bit          m_held;
    int          m_pops;
    int          m_stalls;
    int          n_checks;
    int          n_pass;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [47:0] rnd48();
        return {16'($urandom), 32'($urandom)};
    endfunction

    // One cycle: drive at negedge, compare combinational pop against model, advance model
    task automatic cycle(input logic [20:0] lbv, input logic [20:0] mf, input logic rdy,
                         input logic [47:0] d, output int obs);
        int exp_g;
        exp_g = -1;
        @(negedge clock);
        lb_valid  = lbv;
        mshr_free = mf;
        out_ready = rdy;
        lb_data   = d;
        #1;
        if (!m_held || rdy) begin
            for (int k = 0; k < NQ; k++) begin
                int q;
                q = (m_ptr + k) % NQ;
                if (lbv[q] && mf[q] && !m_claimed[q]) begin
                    exp_g = q;
                    break;
                end
            end
        end
        obs = lb_pop_valid ? int'(lb_pop_bits) : -1;
        chk("out_valid", out_valid, m_held);
        chk("pop_valid", lb_pop_valid, exp_g >= 0);
        chk("pop_bits", lb_pop_bits, (exp_g >= 0) ? exp_g : 0);
        if (m_held && !rdy) m_stalls++;
        m_claimed &= mf;
        if (exp_g >= 0) begin
            m_claimed[exp_g] = 1'b1;
            m_ptr  = (exp_g + 1) % NQ;
            sb.push_back('{exp_g, d});
            m_pops++;
            m_held = 1'b1;
        end else if (rdy) begin
            m_held = 1'b0;
        end
    endtask

    // Monitor: every accepted output must match the oldest predicted entry
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            #2;
            if (reset && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL sb_underflow: got out_idx %0d expected no output", out_idx);
                end else begin
                    e = sb.pop_front();
                    chk("out_idx", out_idx, e.idx);
                    chk("out_data", out_data, e.data);
                end
            end
        end
    end

    initial begin
        int          obs;
        int          prev;
        logic [47:0] d5;
        logic [20:0] mf;
        n_checks = 0; n_pass = 0;
        m_claimed = '0; m_ptr = 0; m_held = 0; m_pops = 0; m_stalls = 0;
        reset = 1'b0; lb_valid = '0; mshr_free = '0; out_ready = 1'b0; lb_data = '0;
        repeat (3) @(negedge clock);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_pop_valid", lb_pop_valid, 0);
        reset = 1'b1;

        // Single request on q3, claim blocks until MSHR busy
        cycle(21'h8, '1, 1'b1, rnd48(), obs);
        chk("q3_pop", obs, 3);
        cycle(21'h8, '1, 1'b1, rnd48(), obs);
        chk("q3_claimed", obs, -1);
        cycle(21'h8, ~21'h8, 1'b1, rnd48(), obs);
        cycle(21'h8, '1, 1'b1, rnd48(), obs);
        chk("q3_repop", obs, 3);

        // Round-robin sweep starting from 0
        cycle('0, '0, 1'b1, '0, obs);
        cycle(21'h100000, '1, 1'b1, rnd48(), obs);
        prev = 20;
        for (int k = 0; k <= NQ; k++) begin
            mf = ~(21'(1) << prev);
            cycle('1, mf, 1'b1, rnd48(), obs);
            chk("rr_order", obs, k % NQ);
            prev = (obs >= 0) ? obs : 0;
        end

        // Backpressure holds the entry and blocks pops
        cycle('0, '0, 1'b1, '0, obs);
        d5 = rnd48();
        cycle(21'h20, '1, 1'b0, d5, obs);
        chk("bp_pop5", obs, 5);
        for (int k = 0; k < 10; k++) begin
            cycle(21'h40, '1, 1'b0, rnd48(), obs);
            chk("bp_nopop", obs, -1);
            chk("bp_stable_data", out_data, d5);
            chk("bp_stable_idx", out_idx, 5);
        end
        cycle(21'h40, '1, 1'b1, rnd48(), obs);
        chk("bp_pop6", obs, 6);
        cycle('0, '1, 1'b1, '0, obs);
        chk("bp_idx6", out_idx, 6);

        // MSHR busy: q0 never popped
        cycle('0, '0, 1'b1, '0, obs);
        for (int k = 0; k < 5; k++) begin
            cycle(21'h3, 21'h2, 1'b1, rnd48(), obs);
            chk("busy_no_q0", obs == 0, 0);
        end

        // Wrap from 20 to 0
        cycle('0, '0, 1'b1, '0, obs);
        cycle(21'h080000, '1, 1'b1, rnd48(), obs);
        chk("wrap_q19", obs, 19);
        cycle(21'h100001, '1, 1'b1, rnd48(), obs);
        chk("wrap_q20", obs, 20);
        cycle(21'h100001, '1, 1'b1, rnd48(), obs);
        chk("wrap_q0", obs, 0);

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            cycle(21'($urandom), 21'($urandom | $urandom), ($urandom % 4) != 0, rnd48(), obs);
        end

        // Reset mid-operation with a held request
        cycle('0, '0, 1'b1, '0, obs);
        cycle(21'h4, '1, 1'b0, rnd48(), obs);
        @(negedge clock);
        #3;
        reset = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_idx", out_idx, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_pop_valid", lb_pop_valid, 0);
        lb_valid = '0; mshr_free = '0; out_ready = 1'b0;
        m_claimed = '0; m_ptr = 0; m_held = 0; m_pops = 0; m_stalls = 0;
        sb.delete();
        @(negedge clock);
        #3;
        reset = 1'b1;
        #1;
`ifdef LB_POP_ARB_STATS_EN
        chk("stat_pops_clr", stat_pops, 0);
`endif
        cycle('1, '1, 1'b1, rnd48(), obs);
        chk("post_rst_q0", obs, 0);

        for (int k = 0; k < 500; k++) begin
            cycle(21'($urandom), 21'($urandom | $urandom), ($urandom % 3) != 0, rnd48(), obs);
        end
        repeat (3) cycle('0, '1, 1'b1, '0, obs);
        chk("sb_drained", sb.size(), 0);
`ifdef LB_POP_ARB_STATS_EN
        chk("stat_pops", stat_pops, m_pops);
        chk("stat_stalls", stat_stalls, m_stalls);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lb_pop_arbiter.md
Name: lb_pop_arbiter

Overview:
- Downstream consumer of the 21-queue request ListBuffer in the cache scheduler.
- Each cycle, picks one non-empty queue whose MSHR is free, using round-robin order, and pops that queue's head request.
- Holds the popped request in a one-entry output register and hands it to the MSHR allocation stage over a valid/ready handshake.
- Stops a queue from being popped twice before its MSHR has reported itself busy.

Parameters:
- NUM_Q, 21, number of queues/MSHRs; must match the ListBuffer io_valid width.
- IDX_W, 5, queue index width, ceil(log2(NUM_Q)).
- DATA_W, 48, packed request width.

Ports:
- clock  in  1  single clock; all state on posedge.
- reset  in  1  asynchronous, active-low reset (deasserted = 1).
- lb_valid  in  NUM_Q  per-queue non-empty flags from the ListBuffer io_valid.
- lb_pop_valid  out  1  pop strobe to the ListBuffer io_pop_valid.
- lb_pop_bits  out  IDX_W  queue to pop, to the ListBuffer io_pop_bits.
- lb_data  in  DATA_W  head data for lb_pop_bits, valid in the same cycle.
  - Layout: [0] prio_0, [1] prio_1, [2] prio_2, [3] control, [6:4] opcode, [9:7] param, [12:10] size, [18:13] source, [35:19] tag, [41:36] offset, [47:42] put.
- mshr_free  in  NUM_Q  MSHR i may accept a request.
- out_valid  out  1  output register holds a request.
- out_ready  in  1  consumer accepts this cycle.
- out_idx  out  IDX_W  queue/MSHR index of the held request.
- out_data  out  DATA_W  held request, same layout as lb_data.

Behaviour:
- Eligibility: elig = lb_valid & mshr_free & ~claimed.
- Grant:
  - Round-robin over elig, starting at rr_ptr (inclusive) and wrapping from NUM_Q-1 to 0.
  - grant_idx is the first set bit found.
  - Combinational; no dependence on lb_data.
- Slot availability: slot_free = ~out_valid | out_ready.
- Pop condition:
  - lb_pop_valid = |elig & slot_free.
  - lb_pop_bits = grant_idx when popping, else 0.
  - lb_pop_valid never asserts for a queue whose lb_valid bit is 0.
- Output register, two-state FSM (EMPTY/FULL):
  - EMPTY → FULL on pop.
  - FULL stays FULL on (pop & out_ready), loading the new entry.
  - FULL stays FULL on ~out_ready, holding the entry.
  - FULL → EMPTY on (out_ready & ~pop).
  - Pop latency: out_valid rises the cycle after lb_pop_valid.
  - Throughput: one request per cycle.
- Load on pop: out_data <= lb_data and out_idx <= grant_idx, captured at the pop edge.
- Stability: while out_valid & ~out_ready, out_idx and out_data are stable.
- rr_ptr:
  - On pop, rr_ptr <= grant_idx + 1, with NUM_Q-1 wrapping to 0.
  - Otherwise rr_ptr holds.
- claimed:
  - claimed[i] is set on the pop of queue i.
  - claimed[i] clears in any cycle where mshr_free[i] == 0.
  - Set takes precedence when both happen in the same cycle; that case is impossible, since a pop requires mshr_free[i] == 1.
- Simultaneous events:
  - A queue popped at cycle t is not eligible at t+1, even though lb_valid[i] may still read 1 (the ListBuffer valid register lags).
  - It stays ineligible until its MSHR drops mshr_free.
- Reset (async assert, sync-safe release):
  - out_valid = 0, out_idx = 0, out_data = 0.
  - rr_ptr = 0, claimed = 0, lb_pop_valid = 0.
  - Reset mid-operation discards the held request; the ListBuffer is reset in the same domain.
- Boundaries:
  - All queues empty, or all claimed: no pop.
  - Only one eligible queue: it is granted regardless of rr_ptr.

Optional Feature:
- Macro: LB_POP_ARB_STATS_EN.
- Defined:
  - Adds outputs stat_pops[31:0] and stat_stalls[31:0].
  - stat_pops counts cycles with lb_pop_valid.
  - stat_stalls counts cycles with out_valid & ~out_ready.
  - Both saturate at 0xFFFFFFFF and clear on reset.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package lb_pop_arb_pkg holds:
  - NUM_Q, IDX_W, DATA_W;
  - the field bit offsets for the layout above;
  - typedef req_t, a packed struct matching that layout;
  - enum state_e {EMPTY, FULL}.
- Sub-module rr_pick:
  - Inputs: req[NUM_Q], ptr[IDX_W].
  - Outputs: any, idx[IDX_W].
  - Purely combinational; implemented as a double-width rotate plus priority encode.

Test Plan:
- Request on q3 only: lb_valid = 0x000008, mshr_free all 1, out_ready = 1.
  - lb_pop_valid = 1 with lb_pop_bits = 3 in that cycle.
  - Next cycle: out_valid = 1, out_idx = 3, out_data = the lb_data that was presented.
  - claimed[3] blocks a second pop until mshr_free[3] = 0.
- Round-robin: lb_valid = 0x1FFFFF, mshr_free toggled low for one cycle after each grant.
  - Grants follow the order 0, 1, 2, …, 20, 0, with no skips.
- Backpressure: out_ready = 0 with q5 valid.
  - One pop, then lb_pop_valid stays 0 and out_data is stable for 10 cycles.
  - Raise out_ready with q6 valid: a pop of q6 occurs in that same cycle, and out_idx = 6 on the next cycle.
- MSHR busy: lb_valid = 0x000003, mshr_free = 0x000002.
  - Only q1 is popped; q0 is never popped while mshr_free[0] = 0.
- Wrap: rr_ptr = 20 (after a pop of q19), lb_valid = 0x100001.
  - Grant q20, then grant q0.
- Reset mid-operation: out_valid = 1, then assert reset asynchronously mid-cycle.
  - Outputs are 0 immediately, and rr_ptr/claimed are cleared.
  - After release with stats enabled, stat_pops = 0.
